// File: rtl/mem_access_unit_if.sv
// Request/response handshake and DataMemory port bundle for mem_access_unit.
// master = CPU/system side (also supplies DataMemory read data), slave = the unit.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_size;
   logic        req_signed;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_misaligned;
   logic        mem_wmem;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_memc;
   logic [15:0] mem_rdata;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
             mem_wmem, mem_addr, mem_wdata, mem_memc
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
             mem_wmem, mem_addr, mem_wdata, mem_memc
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU memory stage and DataMemory: splits odd-address
// halfwords into two little-endian byte accesses, extends byte loads, counts misaligned requests.
module mem_access_unit #(
   parameter bit SPLIT_MISALIGNED = 1'b1,
   parameter int CNT_W            = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   mem_access_unit_if.slave bus,
   output logic [CNT_W-1:0] misalign_cnt
);
   typedef enum logic [2:0] {IDLE, SINGLE, LO, HI, DONE} state_t;

   state_t      state_reg, state_next;
   logic        we_reg, size_reg, signed_reg, mis_reg;
   logic [15:0] addr_reg, wdata_reg;
   logic [7:0]  lo_byte_reg;
   logic        mem_wmem_reg, mem_wmem_next;
   logic        mem_memc_reg, mem_memc_next;
   logic [15:0] mem_addr_reg, mem_addr_next;
   logic [15:0] mem_wdata_reg, mem_wdata_next;
   logic        rsp_valid_reg, rsp_mis_reg;
   logic [15:0] rsp_rdata_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic        accept, req_mis, finishing;
   logic [15:0] byte_ext;

   assign accept    = (state_reg == IDLE) && bus.req_valid;
   assign req_mis   = bus.req_size & bus.req_addr[0];
   assign finishing = (state_reg == SINGLE) || (state_reg == HI);

   assign byte_ext[7:0] = bus.mem_rdata[7:0];
   for (genvar gi = 8; gi < 16; gi++) begin : g_sext
      assign byte_ext[gi] = bus.mem_rdata[7] & signed_reg;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Memory-side outputs are computed one state ahead so they come straight from flops.
   always_comb begin
      state_next     = state_reg;
      mem_wmem_next  = 1'b0;
      mem_memc_next  = 1'b0;
      mem_addr_next  = '0;
      mem_wdata_next = '0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               mem_wmem_next = bus.req_we;
               mem_addr_next = bus.req_addr;
               if (req_mis && SPLIT_MISALIGNED) begin
                  state_next     = LO;
                  mem_wdata_next = {8'h00, bus.req_wdata[7:0]};
               end else begin
                  state_next     = SINGLE;
                  mem_memc_next  = bus.req_size;
                  mem_wdata_next = bus.req_wdata;
               end
            end
         end
         SINGLE: state_next = DONE;
         LO: begin
            state_next     = HI;
            mem_wmem_next  = we_reg;
            mem_addr_next  = addr_reg + 16'd1;
            mem_wdata_next = {8'h00, wdata_reg[15:8]};
         end
         HI:      state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         we_reg        <= 1'b0;
         size_reg      <= 1'b0;
         signed_reg    <= 1'b0;
         mis_reg       <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         lo_byte_reg   <= '0;
         mem_wmem_reg  <= 1'b0;
         mem_memc_reg  <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_mis_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
         cnt_reg       <= '0;
      end else begin
         mem_wmem_reg  <= mem_wmem_next;
         mem_memc_reg  <= mem_memc_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         rsp_valid_reg <= finishing;
         if (accept) begin
            we_reg     <= bus.req_we;
            size_reg   <= bus.req_size;
            signed_reg <= bus.req_signed;
            mis_reg    <= req_mis;
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
            if (req_mis && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;
         end
         if (finishing) rsp_mis_reg <= mis_reg;
         if (state_reg == SINGLE && !we_reg)
            rsp_rdata_reg <= size_reg ? bus.mem_rdata : byte_ext;
         if (state_reg == LO) lo_byte_reg <= bus.mem_rdata[7:0];
         if (state_reg == HI && !we_reg)
            rsp_rdata_reg <= {bus.mem_rdata[7:0], lo_byte_reg};
      end
   end

   assign bus.req_ready      = (state_reg == IDLE);
   assign bus.rsp_valid      = rsp_valid_reg;
   assign bus.rsp_rdata      = rsp_rdata_reg;
   assign bus.rsp_misaligned = rsp_mis_reg;
   assign bus.mem_wmem       = mem_wmem_reg;
   assign bus.mem_addr       = mem_addr_reg;
   assign bus.mem_wdata      = mem_wdata_reg;
   assign bus.mem_memc       = mem_memc_reg;
   assign misalign_cnt       = cnt_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: split and non-split instances share one request stream,
// each with its own DataMemory model; results are checked against a byte-array reference.
module tb_mem_access_unit;
   logic CLK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLK = ~CLK;

   mem_access_unit_if u ();
   mem_access_unit_if u0 ();
   logic [7:0] cnt, cnt0;

   mem_access_unit #(.SPLIT_MISALIGNED(1'b1), .CNT_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .bus(u.slave), .misalign_cnt(cnt));
   mem_access_unit #(.SPLIT_MISALIGNED(1'b0), .CNT_W(8)) dut0 (
      .CLK(CLK), .RESET(RESET), .bus(u0.slave), .misalign_cnt(cnt0));

   logic        req_valid = 1'b0, req_we = 1'b0, req_size = 1'b0, req_signed = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0;
   assign u.req_valid  = req_valid;  assign u0.req_valid  = req_valid;
   assign u.req_we     = req_we;     assign u0.req_we     = req_we;
   assign u.req_size   = req_size;   assign u0.req_size   = req_size;
   assign u.req_signed = req_signed; assign u0.req_signed = req_signed;
   assign u.req_addr   = req_addr;   assign u0.req_addr   = req_addr;
   assign u.req_wdata  = req_wdata;  assign u0.req_wdata  = req_wdata;

   // DataMemory models: halfword accesses align down, byte reads carry junk in the upper byte.
   logic [7:0] mem  [65536] = '{default: 8'h00};
   logic [7:0] mem0 [65536] = '{default: 8'h00};
   always_comb begin
      if (u.mem_memc) u.mem_rdata = {mem[{u.mem_addr[15:1], 1'b1}], mem[{u.mem_addr[15:1], 1'b0}]};
      else            u.mem_rdata = {8'hC3, mem[u.mem_addr]};
   end
   always_comb begin
      if (u0.mem_memc) u0.mem_rdata = {mem0[{u0.mem_addr[15:1], 1'b1}], mem0[{u0.mem_addr[15:1], 1'b0}]};
      else             u0.mem_rdata = {8'hC3, mem0[u0.mem_addr]};
   end
   always @(posedge CLK) begin
      if (u.mem_wmem) begin
         if (u.mem_memc) begin
            mem[{u.mem_addr[15:1], 1'b0}] <= u.mem_wdata[7:0];
            mem[{u.mem_addr[15:1], 1'b1}] <= u.mem_wdata[15:8];
         end else mem[u.mem_addr] <= u.mem_wdata[7:0];
      end
      if (u0.mem_wmem) begin
         if (u0.mem_memc) begin
            mem0[{u0.mem_addr[15:1], 1'b0}] <= u0.mem_wdata[7:0];
            mem0[{u0.mem_addr[15:1], 1'b1}] <= u0.mem_wdata[15:8];
         end else mem0[u0.mem_addr] <= u0.mem_wdata[7:0];
      end
   end

   // Reference model: little-endian byte array plus response/counter state.
   logic [7:0]  ref_mem [65536] = '{default: 8'h00};
   logic [15:0] last_load = '0;
   int          mis_count = 0;

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_load(input logic sz, input logic sg, input logic [15:0] a);
      logic [15:0] a1;
      logic [7:0]  b;
      a1 = a + 16'd1;
      b  = ref_mem[a];
      if (sz) return {ref_mem[a1], b};
      return {{8{sg & b[7]}}, b};
   endfunction

   int          r_lat, r_lat0, r_wc, r_wc0;
   logic [15:0] r_rd, r_rd0;
   logic        r_mis, r_mis0;

   task automatic do_req(input logic we, input logic sz, input logic sg,
                         input logic [15:0] a, input logic [15:0] d);
      int  k;
      bit  seen, seen0;
      @(negedge CLK);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
      k = 0;
      while (!u.req_ready && k < 20) begin
         @(negedge CLK);
         k++;
      end
      chk("accept_timeout", {31'd0, u.req_ready}, 32'd1);
      @(posedge CLK);
      r_lat = 0; r_lat0 = 0; r_wc = 0; r_wc0 = 0; seen = 0; seen0 = 0;
      r_rd = '0; r_rd0 = '0; r_mis = 1'b0; r_mis0 = 1'b0;
      for (int c = 1; c <= 8 && !(seen && seen0); c++) begin
         @(negedge CLK);
         if (c == 1) req_valid = 1'b0;
         if (u.mem_wmem)  r_wc++;
         if (u0.mem_wmem) r_wc0++;
         if (!seen && u.rsp_valid) begin
            seen = 1; r_lat = c; r_rd = u.rsp_rdata; r_mis = u.rsp_misaligned;
         end
         if (!seen0 && u0.rsp_valid) begin
            seen0 = 1; r_lat0 = c; r_rd0 = u0.rsp_rdata; r_mis0 = u0.rsp_misaligned;
         end
      end
   endtask

   task automatic run_txn(input logic we, input logic sz, input logic sg,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input bit chk_rd0,
                          input logic [15:0] exp_rd0, input int exp_cnt);
      logic        mis;
      logic [15:0] a1;
      mis = sz & a[0];
      do_req(we, sz, sg, a, d);
      $display("txn we=%0d sz=%0d sg=%0d addr=%h wdata=%h -> rdata=%h lat=%0d mis=%0d cnt=%0d | nosplit rdata=%h lat=%0d",
               we, sz, sg, a, d, r_rd, r_lat, r_mis, cnt, r_rd0, r_lat0);
      chk("latency", r_lat, mis ? 3 : 2);
      chk("rsp_misaligned", {31'd0, r_mis}, {31'd0, mis});
      chk("rsp_rdata", {16'd0, r_rd}, {16'd0, exp_rd});
      chk("wmem_cycles", r_wc, we ? (mis ? 2 : 1) : 0);
      chk("misalign_cnt", {24'd0, cnt}, exp_cnt);
      chk("nosplit_latency", r_lat0, 2);
      chk("nosplit_misaligned", {31'd0, r_mis0}, {31'd0, mis});
      chk("nosplit_wmem_cycles", r_wc0, we ? 1 : 0);
      chk("nosplit_misalign_cnt", {24'd0, cnt0}, exp_cnt);
      if (chk_rd0) chk("nosplit_rsp_rdata", {16'd0, r_rd0}, {16'd0, exp_rd0});
      if (we) begin
         a1 = a + 16'd1;
         ref_mem[a] = d[7:0];
         if (sz) ref_mem[a1] = d[15:8];
      end else last_load = exp_rd;
      if (mis && mis_count < 255) mis_count++;
   endtask

   typedef struct {
      logic        we, sz, sg;
      logic [15:0] a, d, rd, rd0;
      int          cnt;
   } vec_t;
   vec_t tbl [11];

   task automatic check_reset_state(input string tag);
      chk({tag, "_req_ready"}, {31'd0, u.req_ready}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, u.rsp_valid}, 32'd0);
      chk({tag, "_rsp_rdata"}, {16'd0, u.rsp_rdata}, 32'd0);
      chk({tag, "_rsp_misaligned"}, {31'd0, u.rsp_misaligned}, 32'd0);
      chk({tag, "_mem_wmem"}, {31'd0, u.mem_wmem}, 32'd0);
      chk({tag, "_mem_addr"}, {16'd0, u.mem_addr}, 32'd0);
      chk({tag, "_mem_wdata"}, {16'd0, u.mem_wdata}, 32'd0);
      chk({tag, "_mem_memc"}, {31'd0, u.mem_memc}, 32'd0);
      chk({tag, "_misalign_cnt"}, {24'd0, cnt}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pulses, last, mingap, maxgap, diffs, wm, rv;
      logic        we, sz, sg, mis;
      logic [15:0] a, d, exp_rd;
      int          exp_cnt;

      //           we    sz    sg    addr      wdata     rdata     rdata(no split) cnt
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h1004, 16'hBEEF, 16'h0000, 16'h0000, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h1004, 16'h0000, 16'hBEEF, 16'hBEEF, 0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h1005, 16'h0080, 16'hBEEF, 16'hBEEF, 0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h1005, 16'h0000, 16'hFF80, 16'hFF80, 0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h1005, 16'h0000, 16'h0080, 16'h0080, 0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h1007, 16'h1234, 16'h0080, 16'h0080, 1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h1007, 16'h0000, 16'h1234, 16'h1234, 2};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h1008, 16'h0000, 16'h0012, 16'h0000, 2};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hA55A, 16'h0012, 16'h0000, 3};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA55A, 16'hA55A, 4};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFA5, 16'h0000, 4};

      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_state("reset");
      RESET = 1'b1;

      for (int i = 0; i < 11; i++)
         run_txn(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d,
                 tbl[i].rd, 1'b1, tbl[i].rd0, tbl[i].cnt);

      // Randomized traffic around a small window and the 0xFFFF/0x0000 wrap.
      for (int i = 0; i < 150; i++) begin
         we = $urandom_range(0, 99) < 40;
         sz = $urandom_range(0, 1);
         sg = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) a = 16'hFFFE + 16'($urandom_range(0, 3));
         else                          a = 16'h3000 + 16'($urandom_range(0, 31));
         d = 16'($urandom);
         mis = sz & a[0];
         exp_rd  = we ? last_load : model_load(sz, sg, a);
         exp_cnt = (mis && mis_count < 255) ? mis_count + 1 : mis_count;
         run_txn(we, sz, sg, a, d, exp_rd, 1'b0, 16'h0000, exp_cnt);
      end

      // Request held high: one accept per IDLE visit, counter saturates.
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b0; req_size = 1'b1; req_signed = 1'b0;
      req_addr = 16'h2001; req_wdata = 16'h0000;
      pulses = 0; last = -1; mingap = 1000; maxgap = 0;
      for (int c = 0; c < 3000 && pulses < 260; c++) begin
         @(negedge CLK);
         if (u.rsp_valid) begin
            if (last >= 0) begin
               if (c - last < mingap) mingap = c - last;
               if (c - last > maxgap) maxgap = c - last;
            end
            last = c;
            pulses++;
         end
      end
      req_valid = 1'b0;
      last_load = model_load(1'b1, 1'b0, 16'h2001);
      mis_count = 255;
      $display("txn held misaligned loads: pulses=%0d gap=%0d..%0d cnt=%0d cnt_nosplit=%0d",
               pulses, mingap, maxgap, cnt, cnt0);
      chk("held_pulses", pulses, 260);
      chk("held_min_gap", mingap, 4);
      chk("held_max_gap", maxgap, 4);
      chk("held_rdata", {16'd0, u.rsp_rdata}, {16'd0, last_load});
      chk("saturated_cnt", {24'd0, cnt}, 32'hFF);
      chk("nosplit_saturated_cnt", {24'd0, cnt0}, 32'hFF);
      repeat (4) @(negedge CLK);

      // Reset during HI of a split store: only the low byte lands.
      run_txn(1'b1, 1'b1, 1'b0, 16'h4001, 16'h2211, last_load, 1'b0, 16'h0000, 255);
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_signed = 1'b0;
      req_addr = 16'h4001; req_wdata = 16'hCDAB;
      @(posedge CLK);
      @(negedge CLK);
      req_valid = 1'b0;
      chk("lo_wmem", {31'd0, u.mem_wmem}, 32'd1);
      chk("lo_addr", {16'd0, u.mem_addr}, 32'h4001);
      @(negedge CLK);
      chk("hi_wmem", {31'd0, u.mem_wmem}, 32'd1);
      chk("hi_addr", {16'd0, u.mem_addr}, 32'h4002);
      RESET = 1'b0;
      #1;
      check_reset_state("midop");
      @(negedge CLK);
      RESET = 1'b1;
      wm = 0; rv = 0;
      repeat (6) begin
         @(negedge CLK);
         if (u.mem_wmem)  wm++;
         if (u.rsp_valid) rv++;
      end
      $display("txn reset during split store: lo=%h hi=%h", mem[16'h4001], mem[16'h4002]);
      chk("after_reset_wmem", wm, 0);
      chk("after_reset_rsp_valid", rv, 0);
      chk("lo_byte_written", {24'd0, mem[16'h4001]}, 32'hAB);
      chk("hi_byte_unwritten", {24'd0, mem[16'h4002]}, 32'h22);
      ref_mem[16'h4001] = 8'hAB;
      last_load = '0;
      mis_count = 0;
      run_txn(1'b0, 1'b1, 1'b0, 16'h4001, 16'h0000, 16'h22AB, 1'b0, 16'h0000, 1);

      diffs = 0;
      for (int i = 0; i < 65536; i++)
         if (mem[i] !== ref_mem[i]) diffs++;
      chk("memory_image_diffs", diffs, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
